// File: rtl/wb_cmsdk_uart_pkg.sv
// Shared constants for the CMSDK-style UART: register map, bit positions, RX states, ID bytes.
// No logic; imported by wb_cmsdk_uart and wb_cmsdk_uart_rx.
package wb_cmsdk_uart_pkg;

  localparam logic [9:0] ADR_DATA  = 10'h000;
  localparam logic [9:0] ADR_STATE = 10'h001;
  localparam logic [9:0] ADR_CTRL  = 10'h002;
  localparam logic [9:0] ADR_INT   = 10'h003;
  localparam logic [9:0] ADR_BAUD  = 10'h004;

  localparam int ST_TXF = 0;
  localparam int ST_RXF = 1;
  localparam int ST_TXO = 2;
  localparam int ST_RXO = 3;

  localparam int CT_TXEN = 0;
  localparam int CT_RXEN = 1;

  localparam int IN_TX  = 0;
  localparam int IN_RX  = 1;
  localparam int IN_TXO = 2;
  localparam int IN_RXO = 3;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // PID4..7, PID0..3, CID0..3 at the top of the 4 KB window
  function automatic logic [7:0] id_byte(input logic [9:0] adr);
    case (adr)
      10'h3F4: id_byte = 8'h04;
      10'h3F8: id_byte = 8'h21;
      10'h3F9: id_byte = 8'hB8;
      10'h3FA: id_byte = 8'h1B;
      10'h3FC: id_byte = 8'h0D;
      10'h3FD: id_byte = 8'hF0;
      10'h3FE: id_byte = 8'h05;
      10'h3FF: id_byte = 8'hB1;
      default: id_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/wb_cmsdk_uart_rx.sv
// wb_cmsdk_uart_rx: 2-FF synchronised 8N1 receiver with its own baud counter.
// Latency: o_vld pulses one clock after the mid-stop-bit sample; o_ferr qualifies it.
// Backpressure: none; the parent must take the byte on the o_vld pulse.
module wb_cmsdk_uart_rx
  import wb_cmsdk_uart_pkg::*;
#(
  parameter int BAUD_W  = 20,
  parameter int MIN_DIV = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_rxd,
  input  logic              i_en,
  input  logic [BAUD_W-1:0] i_baud,
  output logic [7:0]        o_dat,
  output logic              o_vld,
  output logic              o_ferr
);

  // sync[1] is the synchronised line, sync[2] its previous value for edge detection
  logic [2:0]        sync;
  rx_state_t         state;
  logic [BAUD_W-1:0] cnt;
  logic [2:0]        bitn;
  logic [7:0]        sr;
  logic              baud_ok, rxs, fall, half_done, bit_done;

  assign baud_ok   = i_baud >= BAUD_W'(MIN_DIV);
  assign rxs       = sync[1];
  assign fall      = sync[2] & ~sync[1];
  assign half_done = cnt == (i_baud >> 1) - BAUD_W'(1);
  assign bit_done  = cnt == i_baud - BAUD_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync   <= 3'b111;
      state  <= RX_IDLE;
      cnt    <= '0;
      bitn   <= '0;
      sr     <= '0;
      o_dat  <= '0;
      o_vld  <= 1'b0;
      o_ferr <= 1'b0;
    end else begin
      sync   <= {sync[1:0], i_rxd};
      o_vld  <= 1'b0;
      o_ferr <= 1'b0;
      if (!baud_ok) begin
        state <= RX_IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          RX_IDLE: begin
            if (i_en && fall) begin
              state <= RX_START;
              cnt   <= '0;
            end
          end
          RX_START: begin
            if (half_done) begin
              cnt   <= '0;
              bitn  <= '0;
              state <= rxs ? RX_IDLE : RX_DATA;
            end else begin
              cnt <= cnt + BAUD_W'(1);
            end
          end
          RX_DATA: begin
            if (bit_done) begin
              cnt  <= '0;
              sr   <= {rxs, sr[7:1]};
              bitn <= bitn + 3'd1;
              if (bitn == 3'd7) state <= RX_STOP;
            end else begin
              cnt <= cnt + BAUD_W'(1);
            end
          end
          RX_STOP: begin
            if (bit_done) begin
              cnt    <= '0;
              state  <= RX_IDLE;
              o_vld  <= 1'b1;
              o_ferr <= ~rxs;
              if (rxs) o_dat <= sr;
            end else begin
              cnt <= cnt + BAUD_W'(1);
            end
          end
          default: state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/wb_cmsdk_uart.sv
// wb_cmsdk_uart: CMSDK-style 8N1 UART on a zero-wait Wishbone slave; CMSDK_UART_ID_REGS_EN adds ID regs.
// Latency: ack same cycle, reads combinational, writes at the acked edge; TX load one clock after TXfull.
// Backpressure: none on the bus; a write to a full TX buffer is dropped and flagged as overrun.
module wb_cmsdk_uart
  import wb_cmsdk_uart_pkg::*;
#(
  parameter int BAUD_W  = 20,
  parameter int MIN_DIV = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_dev_sel,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [9:0]  i_wb_adr,
  input  logic [19:0] i_wb_dat,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_ack,
  input  logic        i_rxd,
  output logic        o_txd,
  output logic        o_txen
);

  logic [7:0]        tx_buf, rx_buf, rx_dat;
  logic              tx_full, tx_ovr, rx_full, rx_ovr, rx_vld, rx_ferr;
  logic [6:0]        ctrl;
  logic [3:0]        int_st;
  logic [BAUD_W-1:0] baud;
  logic              tx_busy;
  logic [8:0]        tx_sh;
  logic [3:0]        tx_bit;
  logic [BAUD_W-1:0] tx_cnt;
  logic              wr, rd, baud_ok, tx_load, tx_wr, rx_rd, rx_store;

  assign o_wb_ack = i_dev_sel & i_wb_cyc;
  assign wr       = o_wb_ack & i_wb_we;
  assign rd       = o_wb_ack & ~i_wb_we;
  assign baud_ok  = baud >= BAUD_W'(MIN_DIV);
  assign tx_load  = ctrl[CT_TXEN] & ~tx_busy & tx_full & baud_ok;
  assign tx_wr    = wr && (i_wb_adr == ADR_DATA);
  assign rx_rd    = rd && (i_wb_adr == ADR_DATA);
  assign rx_store = rx_vld & ~rx_ferr;
  assign o_txen   = ctrl[CT_TXEN];

  wb_cmsdk_uart_rx #(.BAUD_W(BAUD_W), .MIN_DIV(MIN_DIV)) u_rx (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_rxd   (i_rxd),
    .i_en    (ctrl[CT_RXEN]),
    .i_baud  (baud),
    .o_dat   (rx_dat),
    .o_vld   (rx_vld),
    .o_ferr  (rx_ferr)
  );

  always_comb begin
    o_wb_dat = '0;
    case (i_wb_adr)
      ADR_DATA:  o_wb_dat[7:0] = rx_buf;
      ADR_STATE: o_wb_dat[3:0] = {rx_ovr, tx_ovr, rx_full, tx_full};
      ADR_CTRL:  o_wb_dat[6:0] = ctrl;
      ADR_INT:   o_wb_dat[3:0] = int_st;
      ADR_BAUD:  o_wb_dat[BAUD_W-1:0] = baud;
      default: begin
`ifdef CMSDK_UART_ID_REGS_EN
        o_wb_dat[7:0] = id_byte(i_wb_adr);
`endif
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_buf  <= '0;
      tx_full <= 1'b0;
      tx_ovr  <= 1'b0;
      rx_buf  <= '0;
      rx_full <= 1'b0;
      rx_ovr  <= 1'b0;
      ctrl    <= '0;
      int_st  <= '0;
      baud    <= '0;
      tx_busy <= 1'b0;
      tx_sh   <= '0;
      tx_bit  <= '0;
      tx_cnt  <= '0;
      o_txd   <= 1'b1;
    end else begin
      // Clears come first so a same-cycle set always wins
      if (wr && i_wb_adr == ADR_CTRL) ctrl <= i_wb_dat[6:0];
      if (wr && i_wb_adr == ADR_BAUD) baud <= i_wb_dat[BAUD_W-1:0];
      if (wr && i_wb_adr == ADR_STATE) begin
        if (i_wb_dat[ST_TXO]) tx_ovr <= 1'b0;
        if (i_wb_dat[ST_RXO]) rx_ovr <= 1'b0;
      end
      if (wr && i_wb_adr == ADR_INT) int_st <= int_st & ~i_wb_dat[3:0];

      if (tx_load) begin
        tx_full       <= 1'b0;
        int_st[IN_TX] <= 1'b1;
      end
      if (tx_wr) begin
        if (tx_full && !tx_load) begin
          tx_ovr         <= 1'b1;
          int_st[IN_TXO] <= 1'b1;
        end else begin
          tx_buf  <= i_wb_dat[7:0];
          tx_full <= 1'b1;
        end
      end

      if (rx_store) begin
        rx_buf        <= rx_dat;
        rx_full       <= 1'b1;
        int_st[IN_RX] <= 1'b1;
        if (rx_full && !rx_rd) begin
          rx_ovr         <= 1'b1;
          int_st[IN_RXO] <= 1'b1;
        end
      end else if (rx_rd) begin
        rx_full <= 1'b0;
      end

      // tx_sh holds D0..D7 then the stop bit; the start bit is driven at load
      if (!baud_ok) begin
        tx_busy <= 1'b0;
        tx_cnt  <= '0;
        o_txd   <= 1'b1;
      end else if (tx_load) begin
        tx_busy <= 1'b1;
        tx_sh   <= {1'b1, tx_buf};
        tx_bit  <= '0;
        tx_cnt  <= '0;
        o_txd   <= 1'b0;
      end else if (tx_busy) begin
        if (tx_cnt == baud - BAUD_W'(1)) begin
          tx_cnt <= '0;
          if (tx_bit == 4'd9) begin
            tx_busy <= 1'b0;
          end else begin
            o_txd  <= tx_sh[0];
            tx_sh  <= {1'b1, tx_sh[8:1]};
            tx_bit <= tx_bit + 4'd1;
          end
        end else begin
          tx_cnt <= tx_cnt + BAUD_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_cmsdk_uart.sv
// Bench for wb_cmsdk_uart: register vectors, exact TX waveform, serial monitor and RX driver vs byte queues.
`timescale 1ns/1ps
module tb_wb_cmsdk_uart;

  logic        clk = 1'b0;
  logic        reset, dev_sel, cyc, we, rxd;
  logic [9:0]  adr;
  logic [19:0] wdat;
  logic [31:0] rdat;
  logic        ack, txd, txen;

  always #5 clk = ~clk;

  wb_cmsdk_uart dut (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_dev_sel (dev_sel),
    .i_wb_cyc  (cyc),
    .i_wb_we   (we),
    .i_wb_adr  (adr),
    .i_wb_dat  (wdat),
    .o_wb_dat  (rdat),
    .o_wb_ack  (ack),
    .i_rxd     (rxd),
    .o_txd     (txd),
    .o_txen    (txen)
  );

`ifdef CMSDK_UART_ID_REGS_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [9:0]  adr;
    logic [19:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cur_baud = 16;
  bit          mon_en = 1'b0;
  logic [7:0]  tx_got[$];
  logic [7:0]  tx_exp[$];
  logic [7:0]  mon_b;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, exp);
    end
  endtask

  task automatic bus_set(input logic w, input logic [9:0] a, input logic [19:0] d);
    @(negedge clk);
    dev_sel = 1'b1; cyc = 1'b1; we = w; adr = a; wdat = d;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    dev_sel = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  task automatic bus_wr(input logic [9:0] a, input logic [19:0] d);
    bus_set(1'b1, a, d);
    bus_idle();
  endtask

  task automatic bus_rd(input logic [9:0] a, output logic [31:0] d);
    bus_set(1'b0, a, 20'h0);
    #1 d = rdat;
    bus_idle();
  endtask

  task automatic rd_chk(input string name, input logic [9:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    chk(name, d, exp);
  endtask

  task automatic set_baud(input int b);
    cur_baud = b;
    bus_wr(10'd4, 20'(b));
  endtask

  // Serial frame on i_rxd, LSB first, each bit held for baud clocks
  task automatic rx_send(input logic [7:0] b, input int baud, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = f[i];
      repeat (baud) @(negedge clk);
    end
    rxd = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic tx_settle(input string name);
    int t;
    t = 0;
    while (tx_got.size() < tx_exp.size() && t < 4000) begin
      @(negedge clk);
      t++;
    end
    repeat (12 * cur_baud) @(negedge clk);
    chk({name, "_count"}, tx_got.size(), tx_exp.size());
    for (int i = 0; i < tx_exp.size() && i < tx_got.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), {24'h0, tx_got[i]}, {24'h0, tx_exp[i]});
    tx_got.delete();
    tx_exp.delete();
  endtask

  // Independent UART receiver watching o_txd, sampling mid-bit
  always @(negedge clk) begin
    if (mon_en && txd === 1'b0) begin
      repeat (cur_baud / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (cur_baud) @(negedge clk);
        mon_b[i] = txd;
      end
      repeat (cur_baud) @(negedge clk);
      chk("tx_stop_bit", {31'h0, txd}, 32'h1);
      tx_got.push_back(mon_b);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0]  f;
    logic [31:0] d;
    logic [7:0]  b0, b1;
    int          errs, lows, bd, gap;
    logic [9:0]  ra;

    reset = 1'b1; dev_sel = 1'b0; cyc = 1'b0; we = 1'b0;
    adr = '0; wdat = '0; rxd = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;

    // Reset state
    chk("reset_txd", {31'h0, txd}, 32'h1);
    chk("reset_txen", {31'h0, txen}, 32'h0);
    for (int a = 0; a < 5; a++) rd_chk($sformatf("reset_reg%0d", a), 10'(a), 32'h0);

    bus_wr(10'd2, 20'h3);
    chk("txen_on", {31'h0, txen}, 32'h1);
    rd_chk("ctrl_3", 10'd2, 32'h3);
    bus_wr(10'd2, 20'h0);
    chk("txen_off", {31'h0, txen}, 32'h0);

    // Bus handshake and select gating
    bus_set(1'b0, 10'd2, 20'h0);
    #1 chk("ack_sel", {31'h0, ack}, 32'h1);
    @(negedge clk);
    dev_sel = 1'b0; cyc = 1'b1; we = 1'b1; adr = 10'd2; wdat = 20'h3;
    #1 chk("ack_no_sel", {31'h0, ack}, 32'h0);
    bus_idle();
    rd_chk("ctrl_no_sel", 10'd2, 32'h0);

    vecs.push_back('{name:"ctrl_mask",   adr:10'd2,   wd:20'hFFFFF, exp:32'h7F});
    vecs.push_back('{name:"ctrl_zero",   adr:10'd2,   wd:20'h00000, exp:32'h0});
    vecs.push_back('{name:"baud_max",    adr:10'd4,   wd:20'hFFFFF, exp:32'hFFFFF});
    vecs.push_back('{name:"baud_mid",    adr:10'd4,   wd:20'h12345, exp:32'h12345});
    vecs.push_back('{name:"unmapped5",   adr:10'd5,   wd:20'hABCDE, exp:32'h0});
    vecs.push_back('{name:"unmapped3f3", adr:10'h3F3, wd:20'h00001, exp:32'h0});
    vecs.push_back('{name:"state_w1c",   adr:10'd1,   wd:20'h0000F, exp:32'h0});
    vecs.push_back('{name:"int_w1c",     adr:10'd3,   wd:20'h0000F, exp:32'h0});
    vecs.push_back('{name:"id_pid4",     adr:10'h3F4, wd:20'h000FF, exp:ID_EN ? 32'h04 : 32'h0});
    vecs.push_back('{name:"id_pid5",     adr:10'h3F5, wd:20'h000FF, exp:32'h0});
    vecs.push_back('{name:"id_pid0",     adr:10'h3F8, wd:20'h00000, exp:ID_EN ? 32'h21 : 32'h0});
    vecs.push_back('{name:"id_pid1",     adr:10'h3F9, wd:20'h00000, exp:ID_EN ? 32'hB8 : 32'h0});
    vecs.push_back('{name:"id_pid2",     adr:10'h3FA, wd:20'h00000, exp:ID_EN ? 32'h1B : 32'h0});
    vecs.push_back('{name:"id_cid3",     adr:10'h3FF, wd:20'h00000, exp:ID_EN ? 32'hB1 : 32'h0});
    foreach (vecs[i]) begin
      bus_wr(vecs[i].adr, vecs[i].wd);
      rd_chk(vecs[i].name, vecs[i].adr, vecs[i].exp);
    end

    // Random register writes against width masks
    for (int i = 0; i < 8; i++) begin
      d = $urandom;
      case ($urandom_range(0, 2))
        0: begin ra = 10'd2; bus_wr(ra, d[19:0]); rd_chk("rand_ctrl", ra, {25'h0, d[6:0]}); end
        1: begin ra = 10'd4; bus_wr(ra, d[19:0]); rd_chk("rand_baud", ra, {12'h0, d[19:0]}); end
        default: begin
          ra = 10'($urandom_range(5, 10'h3F3));
          bus_wr(ra, d[19:0]);
          rd_chk("rand_unmapped", ra, 32'h0);
        end
      endcase
    end
    bus_wr(10'd2, 20'h0);

    // Exact TX waveform for 0xA5 at BAUDDIV=16
    set_baud(16);
    bus_wr(10'd2, 20'h1);
    bus_set(1'b1, 10'd0, 20'hA5);
    bus_idle();
    chk("tx_idle_before_load", {31'h0, txd}, 32'h1);
    f = {1'b1, 8'hA5, 1'b0};
    for (int k = 0; k < 10; k++) begin
      errs = 0;
      for (int s = 0; s < 16; s++) begin
        @(negedge clk);
        if (txd !== f[k]) errs++;
      end
      chk($sformatf("tx_a5_bit%0d", k), errs, 0);
    end
    tx_exp.push_back(8'hA5);
    tx_settle("tx_a5");
    rd_chk("int_tx", 10'd3, 32'h1);
    bus_wr(10'd3, 20'h1);
    rd_chk("int_tx_clr", 10'd3, 32'h0);

    // Back-to-back writes: third one overruns
    bus_set(1'b1, 10'd0, 20'h11);
    bus_set(1'b1, 10'd0, 20'h22);
    bus_set(1'b1, 10'd0, 20'h33);
    bus_idle();
    rd_chk("state_txovr", 10'd1, 32'h5);
    rd_chk("int_txovr", 10'd3, 32'h5);
    bus_wr(10'd1, 20'h4);
    rd_chk("state_txovr_clr", 10'd1, 32'h1);
    tx_exp.push_back(8'h11);
    tx_exp.push_back(8'h22);
    tx_settle("tx_b2b");
    bus_wr(10'd3, 20'hF);
    rd_chk("int_clr_all", 10'd3, 32'h0);

    // Dropping TXen mid-frame finishes the frame and holds the buffer
    bus_set(1'b1, 10'd0, 20'h3C);
    bus_set(1'b1, 10'd0, 20'hC3);
    bus_idle();
    repeat (40) @(negedge clk);
    bus_wr(10'd2, 20'h0);
    tx_exp.push_back(8'h3C);
    tx_settle("tx_disable");
    rd_chk("state_held", 10'd1, 32'h1);
    bus_wr(10'd2, 20'h1);
    tx_exp.push_back(8'hC3);
    tx_settle("tx_reenable");
    rd_chk("state_drained", 10'd1, 32'h0);

    // Randomised TX: two bytes per random divider
    for (int i = 0; i < 4; i++) begin
      bd = $urandom_range(16, 32);
      set_baud(bd);
      b0 = 8'($urandom);
      b1 = 8'($urandom);
      gap = $urandom_range(0, 3 * bd);
      bus_wr(10'd0, {12'h0, b0});
      repeat (gap) @(negedge clk);
      bus_wr(10'd0, {12'h0, b1});
      tx_exp.push_back(b0);
      tx_exp.push_back(b1);
      tx_settle($sformatf("tx_rand%0d", i));
    end
    rd_chk("state_after_rand_tx", 10'd1, 32'h0);

    // Divider below the minimum keeps TX idle
    set_baud(8);
    bus_wr(10'd0, 20'h77);
    foreach (vecs[i]) if (i < 2) begin
      set_baud(i == 0 ? 8 : 15);
      lows = 0;
      repeat (300) begin
        @(negedge clk);
        if (txd !== 1'b1) lows++;
      end
      chk($sformatf("txd_idle_baud%0d", cur_baud), lows, 0);
      rd_chk($sformatf("tx_pending_baud%0d", cur_baud), 10'd1, 32'h1);
    end
    set_baud(16);
    tx_exp.push_back(8'h77);
    tx_settle("tx_after_min");
    bus_wr(10'd3, 20'hF);

    // RX of 0x5A at 20 clocks per bit
    set_baud(20);
    bus_wr(10'd2, 20'h2);
    rx_send(8'h5A, 20, 1'b1);
    rd_chk("rx_full", 10'd1, 32'h2);
    rd_chk("rx_data_5a", 10'd0, 32'h5A);
    rd_chk("rx_full_clr", 10'd1, 32'h0);
    rd_chk("int_rx", 10'd3, 32'h2);
    bus_wr(10'd3, 20'hF);

    // Two frames without a read: overrun, newest byte kept
    rx_send(8'h01, 20, 1'b1);
    rx_send(8'h02, 20, 1'b1);
    rd_chk("rx_ovr_state", 10'd1, 32'hA);
    rd_chk("rx_ovr_data", 10'd0, 32'h02);
    rd_chk("int_rxovr", 10'd3, 32'hA);
    bus_wr(10'd1, 20'h8);
    rd_chk("rx_ovr_clr", 10'd1, 32'h0);
    bus_wr(10'd3, 20'hF);

    // Short low glitch is rejected
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (300) @(negedge clk);
    rd_chk("rx_glitch", 10'd1, 32'h0);

    // Framing error drops the byte; a following good frame still lands
    rx_send(8'h99, 20, 1'b0);
    rd_chk("rx_ferr_drop", 10'd1, 32'h0);
    rx_send(8'h3C, 20, 1'b1);
    rd_chk("rx_after_ferr", 10'd0, 32'h3C);

    // RX disabled ignores traffic
    bus_wr(10'd2, 20'h0);
    rx_send(8'h55, 20, 1'b1);
    rd_chk("rx_disabled", 10'd1, 32'h0);

    // Randomised RX
    bus_wr(10'd2, 20'h2);
    for (int i = 0; i < 5; i++) begin
      bd = $urandom_range(16, 40);
      set_baud(bd);
      b0 = 8'($urandom);
      rx_send(b0, bd, 1'b1);
      rd_chk($sformatf("rx_rand%0d", i), 10'd0, {24'h0, b0});
      rd_chk($sformatf("rx_rand%0d_state", i), 10'd1, 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
